// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues PCs on the inst_* bus, tracks in-flight reads in order,
// and buffers returned {pc, inst, adel} entries for decode. Flush drops buffered and in-flight fetches.
module ifetch_unit #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);
    localparam int FAW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int PAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [31:0]    fifo_pc_q   [DEPTH];
    logic [31:0]    fifo_pc_d   [DEPTH];
    logic [31:0]    fifo_inst_q [DEPTH];
    logic [31:0]    fifo_inst_d [DEPTH];
    logic           fifo_adel_q [DEPTH];
    logic           fifo_adel_d [DEPTH];
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    pq_pc_q [MAX_OUT];
    logic [31:0]    pq_pc_d [MAX_OUT];
    logic [PAW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [OW-1:0]  out_q, out_d, disc_q, disc_d;

    logic        aligned_s, credit_s, req_s, accept_s, mis_acc_s;
    logic        rsp_s, keep_s, push_s, pop_s, idv_s;
    logic [31:0] push_pc_s, push_inst_s;

    // The pending-PC queue may be a non power-of-two size, so wrap explicitly.
    function automatic logic [PAW-1:0] pq_inc(input logic [PAW-1:0] p);
        if (p == PAW'(MAX_OUT - 1)) begin
            return {PAW{1'b0}};
        end else begin
            return p + PAW'(1);
        end
    endfunction

    // Handshake decisions for the current cycle.
    always_comb begin
        aligned_s = (pc_addr[1:0] == 2'b00);
        credit_s  = ((32'(out_q) + 32'(cnt_q)) < 32'(DEPTH)) && (32'(out_q) < 32'(MAX_OUT));
        req_s     = resetn & pc_valid & aligned_s & credit_s & ~flush;
        accept_s  = req_s & inst_addr_ok;
        mis_acc_s = resetn & pc_valid & ~aligned_s & (out_q == {OW{1'b0}}) &
                    (disc_q == {OW{1'b0}}) & (32'(cnt_q) < 32'(DEPTH)) & ~flush;
        // A data_ok with nothing in flight (e.g. straight after reset) is ignored.
        rsp_s     = resetn & inst_data_ok & (out_q != {OW{1'b0}});
        keep_s    = rsp_s & (disc_q == {OW{1'b0}}) & ~flush;
        push_s    = keep_s | mis_acc_s;
        idv_s     = resetn & (cnt_q != {CW{1'b0}}) & ~flush;
        pop_s     = idv_s & id_ready;
        if (keep_s) begin
            push_pc_s   = pq_pc_q[pq_rd_q];
            push_inst_s = inst_rdata;
        end else begin
            push_pc_s   = pc_addr;
            push_inst_s = 32'h0000_0000;
        end
    end

    assign inst_req  = req_s;
    assign inst_addr = pc_addr;
    assign pc_ready  = accept_s | mis_acc_s;
    assign id_valid  = idv_s;
    assign id_pc     = resetn ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign id_inst   = resetn ? fifo_inst_q[rd_ptr_q] : 32'h0000_0000;
    assign id_adel   = resetn ? fifo_adel_q[rd_ptr_q] : 1'b0;

    // Instruction FIFO next state; flush empties it.
    always_comb begin
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_adel_d = fifo_adel_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (flush) begin
            wr_ptr_d = {FAW{1'b0}};
            rd_ptr_d = {FAW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_d[wr_ptr_q]   = push_pc_s;
                fifo_inst_d[wr_ptr_q] = push_inst_s;
                fifo_adel_d[wr_ptr_q] = mis_acc_s;
                wr_ptr_d              = wr_ptr_q + FAW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + FAW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pending-PC queue, outstanding and discard counters.
    always_comb begin
        pq_pc_d = pq_pc_q;
        pq_wr_d = pq_wr_q;
        pq_rd_d = pq_rd_q;
        out_d   = out_q;
        disc_d  = disc_q;
        if (accept_s) begin
            pq_pc_d[pq_wr_q] = pc_addr;
            pq_wr_d          = pq_inc(pq_wr_q);
        end else begin
            pq_wr_d = pq_wr_q;
        end
        if (rsp_s) begin
            pq_rd_d = pq_inc(pq_rd_q);
        end else begin
            pq_rd_d = pq_rd_q;
        end
        case ({accept_s, rsp_s})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
        // On flush every request still in flight after this edge must be dropped.
        if (flush) begin
            disc_d = rsp_s ? (out_q - OW'(1)) : out_q;
        end else if (rsp_s && (disc_q != {OW{1'b0}})) begin
            disc_d = disc_q - OW'(1);
        end else begin
            disc_d = disc_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0000_0000;
                fifo_inst_q[i] <= 32'h0000_0000;
                fifo_adel_q[i] <= 1'b0;
            end
            for (int j = 0; j < MAX_OUT; j++) begin
                pq_pc_q[j] <= 32'h0000_0000;
            end
            wr_ptr_q <= {FAW{1'b0}};
            rd_ptr_q <= {FAW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            pq_wr_q  <= {PAW{1'b0}};
            pq_rd_q  <= {PAW{1'b0}};
            out_q    <= {OW{1'b0}};
            disc_q   <= {OW{1'b0}};
        end else begin
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_adel_q <= fifo_adel_d;
            pq_pc_q     <= pq_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pq_wr_q     <= pq_wr_d;
            pq_rd_q     <= pq_rd_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a queue-based reference model predicts handshakes and delivered
// entries every cycle; directed scenarios add end-to-end checks on the delivered stream.
module tb_ifetch_unit;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0, resetn = 1'b0, pc_valid = 1'b0, flush = 1'b0;
    logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0, id_ready = 1'b0;
    logic [31:0] pc_addr = 32'h0, inst_rdata = 32'h0;
    logic        pc_ready, inst_req, id_valid, id_adel;
    logic [31:0] inst_addr, id_pc, id_inst;

    ifetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
        .flush(flush), .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic drop; } infl_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;

    infl_t infl_q[$];   // accepted requests awaiting data, oldest first
    ent_t  fifo_m[$];   // entries waiting for decode
    ent_t  got[$];      // entries observed leaving the DUT
    logic  exp_req, exp_mis, exp_ready, exp_idv;
    ent_t  exp_head;
    int    n_vec = 0, n_err = 0, mis_pct = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h2400_0001;
    endfunction

    task automatic drive_bus(input int ok_pct, input int dok_pct);
        inst_addr_ok = (int'($urandom_range(0, 99)) < ok_pct);
        if (infl_q.size() > 0 && int'($urandom_range(0, 99)) < dok_pct) begin
            inst_data_ok = 1'b1;
            inst_rdata   = inst_of(infl_q[0].pc);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
        end
    endtask

    task automatic model_expect();
        int   n_out, n_fifo;
        logic credit;
        n_out     = infl_q.size();
        n_fifo    = fifo_m.size();
        credit    = (n_out + n_fifo < DEPTH) && (n_out < MAX_OUT);
        exp_req   = resetn && pc_valid && (pc_addr[1:0] == 2'b00) && credit && !flush;
        exp_mis   = resetn && pc_valid && (pc_addr[1:0] != 2'b00) && (n_out == 0) &&
                    (n_fifo < DEPTH) && !flush;
        exp_ready = (exp_req && inst_addr_ok) || exp_mis;
        exp_idv   = resetn && (n_fifo > 0) && !flush;
        if (resetn && n_fifo > 0) exp_head = fifo_m[0];
        else exp_head = '0;
    endtask

    task automatic model_step();
        logic  rsp;
        infl_t h, t;
        h = '0;
        @(posedge clk);
        if (!resetn) begin
            infl_q.delete();
            fifo_m.delete();
        end else begin
            rsp = inst_data_ok && (infl_q.size() > 0);
            if (rsp) h = infl_q.pop_front();
            if (flush) begin
                fifo_m.delete();
                for (int i = 0; i < infl_q.size(); i++) begin
                    t = infl_q[i]; t.drop = 1'b1; infl_q[i] = t;
                end
            end else begin
                if (exp_idv && id_ready) fifo_m.delete(0);
                if (rsp && !h.drop) fifo_m.push_back({h.pc, inst_of(h.pc), 1'b0});
                if (exp_mis) fifo_m.push_back({pc_addr, 32'h0, 1'b1});
                if (exp_req && inst_addr_ok) infl_q.push_back({pc_addr, 1'b0});
            end
        end
        #1;
        if (exp_ready) begin
            pc_addr = (pc_addr & 32'hffff_fffc) + 32'd4;
            if (int'($urandom_range(0, 99)) < mis_pct) pc_addr[1:0] = 2'($urandom_range(1, 3));
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; pc_valid = 1'b1; pc_addr = 32'hbfc0_0000; id_ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_bus(100, 100);
            inst_data_ok = 1'b1;
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv}) begin
                n_err++; $display("FAIL reset_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            n_vec++;
            if ({id_pc, id_inst, id_adel} !== exp_head) begin
                n_err++; $display("FAIL reset_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
            end
            model_step();
        end
    endtask

    task automatic test_stream();
        ent_t e;
        got.delete();
        resetn = 1'b1; flush = 1'b0; id_ready = 1'b1; pc_addr = 32'hbfc0_0000;
        for (int c = 0; c < 16; c++) begin
            pc_valid = (c < 12);
            drive_bus(100, 100);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL stream_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL stream_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            if (c == 11) begin
                n_vec++;
                if (got.size() != 10) begin
                    n_err++; $display("FAIL stream_rate delivered %0d exp 10", got.size());
                end
            end
            model_step();
        end
        n_vec++;
        if (got.size() != 12) begin
            n_err++; $display("FAIL stream_count delivered %0d exp 12", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            e.pc = 32'hbfc0_0000 + 32'(i * 4); e.inst = inst_of(e.pc); e.adel = 1'b0;
            n_vec++;
            if (got[i] !== e) begin
                n_err++; $display("FAIL stream_order idx %0d got %h exp %h", i, got[i], e);
            end
        end
    endtask

    task automatic test_backpressure();
        got.delete();
        pc_addr = 32'hbfc0_0100;
        for (int c = 0; c < 24; c++) begin
            id_ready = (c >= 10);
            pc_valid = (c < 14);
            drive_bus(100, 100);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL bp_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL bp_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (c == 9) begin
                n_vec++;
                if (inst_req !== 1'b0) begin
                    n_err++; $display("FAIL bp_nocredit inst_req got %b exp 0", inst_req);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            model_step();
        end
        n_vec++;
        if (got.size() != int'((pc_addr - 32'hbfc0_0100) >> 2)) begin
            n_err++; $display("FAIL bp_count delivered %0d exp %0d", got.size(), (pc_addr - 32'hbfc0_0100) >> 2);
        end
        for (int i = 0; i < got.size(); i++) begin
            n_vec++;
            if (got[i].pc !== 32'hbfc0_0100 + 32'(i * 4)) begin
                n_err++; $display("FAIL bp_order idx %0d got %h exp %h", i, got[i].pc, 32'hbfc0_0100 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_flush();
        got.delete();
        pc_addr = 32'hbfc0_0200; id_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            flush    = (c == 2);
            pc_valid = (c != 2) && (c < 8);
            if (c == 3) pc_addr = 32'hbfc0_0380;
            drive_bus(100, (c < 3) ? 0 : 100);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL flush_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL flush_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            model_step();
        end
        flush = 1'b0;
        n_vec++;
        if (got.size() == 0 || got[0].pc !== 32'hbfc0_0380) begin
            n_err++; $display("FAIL flush_first got %h exp bfc00380", (got.size() > 0) ? got[0].pc : 32'h0);
        end
    endtask

    task automatic test_flush_with_data();
        got.delete();
        pc_addr = 32'hbfc0_0300; id_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            flush    = (c == 2);
            pc_valid = (c != 2) && (c < 7);
            if (c == 3) pc_addr = 32'hbfc0_0400;
            if (c < 2) drive_bus(100, 0);
            else drive_bus(100, 100);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL flushdok_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL flushdok_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            model_step();
        end
        flush = 1'b0;
        n_vec++;
        if (got.size() == 0 || got[0].pc !== 32'hbfc0_0400) begin
            n_err++; $display("FAIL flushdok_first got %h exp bfc00400", (got.size() > 0) ? got[0].pc : 32'h0);
        end
    endtask

    task automatic test_misaligned();
        ent_t e;
        got.delete();
        pc_addr = 32'hbfc0_0000; id_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            pc_valid = (c <= 5);
            if (c == 1) pc_addr = 32'hbfc0_0002;
            drive_bus(100, (c < 4) ? 0 : 100);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL mis_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL mis_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (c >= 1 && c <= 3) begin
                n_vec++;
                if ({inst_req, pc_ready} !== 2'b00) begin
                    n_err++; $display("FAIL mis_hold req/rdy got %b%b exp 00", inst_req, pc_ready);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            model_step();
        end
        e.pc = 32'hbfc0_0002; e.inst = 32'h0; e.adel = 1'b1;
        n_vec++;
        if (got.size() != 2 || got[0].pc !== 32'hbfc0_0000 || got[1] !== e) begin
            n_err++; $display("FAIL mis_stream count %0d second %h exp %h", got.size(), (got.size() > 1) ? got[1] : '0, e);
        end
    endtask

    task automatic test_reset_midop();
        got.delete();
        pc_addr = 32'hbfc0_0500; id_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            resetn   = (c != 3);
            pc_valid = (c < 4) || (c >= 6 && c < 10);
            id_ready = (c >= 4);
            if (c == 6) pc_addr = 32'hbfc0_0600;
            drive_bus(100, (c == 1 || c >= 6) ? 100 : 0);
            if (c == 4 || c == 5) inst_data_ok = 1'b1;
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL rstmid_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv || !resetn) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL rstmid_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            if (c == 4) begin
                n_vec++;
                if ({id_valid, inst_req} !== 2'b00) begin
                    n_err++; $display("FAIL rstmid_after val/req got %b%b exp 00", id_valid, inst_req);
                end
            end
            if (id_valid && id_ready) got.push_back({id_pc, id_inst, id_adel});
            model_step();
        end
        n_vec++;
        if (got.size() == 0 || got[0].pc !== 32'hbfc0_0600) begin
            n_err++; $display("FAIL rstmid_first got %h exp bfc00600", (got.size() > 0) ? got[0].pc : 32'h0);
        end
    endtask

    task automatic test_random();
        logic was_flush;
        was_flush = 1'b0; mis_pct = 5; resetn = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (was_flush) pc_addr = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            pc_valid = ($urandom_range(0, 9) < 8);
            id_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 29) == 0);
            was_flush = flush;
            drive_bus(60, 50);
            model_expect(); #2;
            n_vec++;
            if ({inst_req, pc_ready, id_valid} !== {exp_req, exp_ready, exp_idv} || (exp_req && inst_addr !== pc_addr)) begin
                n_err++; $display("FAIL rand_ctl t=%0t got %b%b%b exp %b%b%b", $time, inst_req, pc_ready, id_valid, exp_req, exp_ready, exp_idv);
            end
            if (exp_idv) begin
                n_vec++;
                if ({id_pc, id_inst, id_adel} !== exp_head) begin
                    n_err++; $display("FAIL rand_head t=%0t got %h/%h/%b exp %h", $time, id_pc, id_inst, id_adel, exp_head);
                end
            end
            model_step();
        end
        flush = 1'b0; mis_pct = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_with_data();
        test_misaligned();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
